// File: rtl/fifo_pkg.sv
// fifo_pkg: shared stream beat type and skid-buffer occupancy encoding.
package fifo_pkg;
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } stream_beat_t;
endpackage

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: 2-entry valid/ready skid buffer; head drives the stream outputs.
module stream_skid_buf import fifo_pkg::*; #(
  parameter type beat_t = stream_beat_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  beat_t      in_beat,
  input  logic       out_ready,
  output beat_t      out_beat,
  output logic       out_valid,
  output logic [1:0] occ
);
  beat_t head, skid;
  logic [1:0] occ_q;
  logic pop, head_ld, skid_ld;
  always_comb begin
    pop = out_valid & out_ready;
    head_ld = pop | (in_valid & (occ_q == OCC_EMPTY));
    skid_ld = in_valid & (occ_q == (pop ? OCC_TWO : OCC_ONE));
  end
  // On a pop the skid moves to head; with one entry a simultaneous capture lands in head directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      skid  <= '0;
      occ_q <= OCC_EMPTY;
    end else begin
      if (head_ld) head <= (occ_q == OCC_TWO) ? skid : in_beat;
      if (skid_ld) skid <= in_beat;
      occ_q <= occ_q + 2'(in_valid) - 2'(pop);
    end
  end
  assign out_beat  = head;
  assign out_valid = occ_q != OCC_EMPTY;
  assign occ       = occ_q;
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a sync FIFO into a registered valid/ready stream with frame markers.
module fifo_stream_reader import fifo_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 4,
  parameter int FCNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [FCNT_WIDTH-1:0] frames_done,
  output logic                  busy
);
  localparam int IW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;
  logic [IW-1:0] idx;
  logic [1:0] occ;
  logic pop, idx_last;
  beat_t in_beat, head;
  always_comb begin
    pop = m_valid & m_ready;
    idx_last = idx == IW'(FRAME_LEN - 1);
    fifo_rd_en = ~reset & en & ~fifo_empty & ((occ != OCC_TWO) | pop);
    in_beat = '{last: idx_last, data: fifo_dout};
  end
  // Word index advances at capture time so frame position survives back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      frames_done <= '0;
    end else begin
      if (fifo_rd_en) idx <= idx_last ? '0 : IW'(idx + 1'b1);
      if (pop & m_last) frames_done <= frames_done + 1'b1;
    end
  end
  stream_skid_buf #(.beat_t(beat_t)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (fifo_rd_en),
    .in_beat  (in_beat),
    .out_ready(m_ready),
    .out_beat (head),
    .out_valid(m_valid),
    .occ      (occ)
  );
  assign m_data = head.data;
  assign m_last = head.last;
  assign busy   = occ != OCC_EMPTY;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed table plus corner sequences on FRAME_LEN=4 and FRAME_LEN=3 instances.
module tb_fifo_stream_reader;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;

  logic en_a = 0, rdy_a = 0, empty_a, rd_a, valid_a, last_a, busy_a;
  logic [7:0] dout_a, data_a;
  logic [15:0] fd_a;
  logic [7:0] mem_a [1024];
  int wp_a = 0, rp_a = 0;
  assign empty_a = wp_a == rp_a;
  assign dout_a  = rd_a ? mem_a[rp_a % 1024] : 8'h00;
  always @(posedge clk) if (rd_a) rp_a <= rp_a + 1;

  logic en_b = 0, rdy_b = 0, empty_b, rd_b, valid_b, last_b, busy_b;
  logic [7:0] dout_b, data_b;
  logic [15:0] fd_b;
  logic [7:0] mem_b [1024];
  int wp_b = 0, rp_b = 0;
  assign empty_b = wp_b == rp_b;
  assign dout_b  = rd_b ? mem_b[rp_b % 1024] : 8'h00;
  always @(posedge clk) if (rd_b) rp_b <= rp_b + 1;

  fifo_stream_reader #(.DATA_WIDTH(8), .FRAME_LEN(4), .FCNT_WIDTH(16)) u_a (
    .clk(clk), .reset(reset), .en(en_a), .fifo_empty(empty_a), .fifo_dout(dout_a),
    .fifo_rd_en(rd_a), .m_data(data_a), .m_valid(valid_a), .m_last(last_a),
    .m_ready(rdy_a), .frames_done(fd_a), .busy(busy_a));

  fifo_stream_reader #(.DATA_WIDTH(8), .FRAME_LEN(3), .FCNT_WIDTH(16)) u_b (
    .clk(clk), .reset(reset), .en(en_b), .fifo_empty(empty_b), .fifo_dout(dout_b),
    .fifo_rd_en(rd_b), .m_data(data_b), .m_valid(valid_b), .m_last(last_b),
    .m_ready(rdy_b), .frames_done(fd_b), .busy(busy_b));

  typedef struct {
    logic en, rdy, rd, valid;
    logic [7:0] data;
    logic last;
  } vec_t;
  vec_t tv [24];

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_a(logic [7:0] v);
    mem_a[wp_a % 1024] = v;
    wp_a++;
  endtask

  task automatic push_b(logic [7:0] v);
    mem_b[wp_b % 1024] = v;
    wp_b++;
  endtask

  task automatic run_vec(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      en_a = tv[i].en;
      rdy_a = tv[i].rdy;
      #1;
      chk($sformatf("vec%0d rd_en", i), rd_a, tv[i].rd);
      chk($sformatf("vec%0d valid", i), valid_a, tv[i].valid);
      if (tv[i].valid) begin
        chk($sformatf("vec%0d data", i), data_a, tv[i].data);
        chk($sformatf("vec%0d last", i), last_a, tv[i].last);
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, got, k;
    logic [7:0] e6 [4];
    // preload, back-to-back drain (rows 0-9); preload, 5 stalled cycles then release (rows 10-23)
    tv[0]  = '{1, 1, 1, 0, 8'h00, 0};
    tv[1]  = '{1, 1, 1, 1, 8'h01, 0};
    tv[2]  = '{1, 1, 1, 1, 8'h02, 0};
    tv[3]  = '{1, 1, 1, 1, 8'h03, 0};
    tv[4]  = '{1, 1, 1, 1, 8'h04, 1};
    tv[5]  = '{1, 1, 1, 1, 8'h05, 0};
    tv[6]  = '{1, 1, 1, 1, 8'h06, 0};
    tv[7]  = '{1, 1, 1, 1, 8'h07, 0};
    tv[8]  = '{1, 1, 0, 1, 8'h08, 1};
    tv[9]  = '{1, 1, 0, 0, 8'h00, 0};
    tv[10] = '{1, 0, 1, 0, 8'h00, 0};
    tv[11] = '{1, 0, 1, 1, 8'h01, 0};
    tv[12] = '{1, 0, 0, 1, 8'h01, 0};
    tv[13] = '{1, 0, 0, 1, 8'h01, 0};
    tv[14] = '{1, 0, 0, 1, 8'h01, 0};
    tv[15] = '{1, 1, 1, 1, 8'h01, 0};
    tv[16] = '{1, 1, 1, 1, 8'h02, 0};
    tv[17] = '{1, 1, 1, 1, 8'h03, 0};
    tv[18] = '{1, 1, 1, 1, 8'h04, 1};
    tv[19] = '{1, 1, 1, 1, 8'h05, 0};
    tv[20] = '{1, 1, 1, 1, 8'h06, 0};
    tv[21] = '{1, 1, 0, 1, 8'h07, 0};
    tv[22] = '{1, 1, 0, 1, 8'h08, 1};
    tv[23] = '{1, 1, 0, 0, 8'h00, 0};

    for (int i = 1; i <= 8; i++) push_a(8'(i));
    en_a = 1;
    rdy_a = 1;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("reset rd_en", rd_a, 0);
      chk("reset valid", valid_a, 0);
      chk("reset data", data_a, 0);
      chk("reset last", last_a, 0);
      chk("reset frames", fd_a, 0);
      chk("reset busy", busy_a, 0);
    end
    en_a = 0;
    reset = 0;

    run_vec(0, 9);
    chk("burst frames", fd_a, 2);
    en_a = 0;
    for (int i = 1; i <= 8; i++) push_a(8'(i));
    run_vec(10, 23);
    chk("stall frames", fd_a, 4);
    chk("stall busy", busy_a, 0);

    en_a = 1;
    rdy_a = 1;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("empty rd_en", rd_a, 0);
    end
    @(negedge clk);
    push_a(8'hA5);
    #1;
    chk("a5 rd_en", rd_a, 1);
    @(negedge clk);
    #1;
    chk("a5 valid", valid_a, 1);
    chk("a5 data", data_a, 8'hA5);
    chk("a5 last", last_a, 0);
    @(negedge clk);
    #1;
    chk("a5 drained", valid_a, 0);

    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 6000 && got < 200; cyc++) begin
      @(negedge clk);
      if (sent < 200 && $urandom_range(1) == 1) begin
        push_b(8'(sent));
        sent++;
      end
      rdy_b = 1'($urandom_range(1));
      en_b = 1;
      #1;
      if (empty_b) chk("rand rd_en empty", rd_b, 0);
      if (valid_b && rdy_b) begin
        chk($sformatf("rand data%0d", got), data_b, got % 256);
        chk($sformatf("rand last%0d", got), last_b, int'(got % 3 == 2));
        got++;
      end
    end
    chk("rand count", got, 200);
    @(negedge clk);
    en_b = 0;
    #1;
    chk("rand frames", fd_b, 66);
    chk("rand busy", busy_b, 0);

    push_b(8'hC0);
    push_b(8'hC1);
    push_b(8'hC2);
    rdy_b = 1;
    repeat (10) begin
      @(negedge clk);
      #1;
      chk("gap rd_en", rd_b, 0);
    end
    chk("gap busy", busy_b, 0);
    @(negedge clk);
    en_b = 1;
    #1;
    chk("resume rd_en", rd_b, 1);
    @(negedge clk);
    #1;
    chk("resume data0", data_b, 8'hC0);
    chk("resume last0", last_b, 1);
    @(negedge clk);
    #1;
    chk("resume data1", data_b, 8'hC1);
    chk("resume last1", last_b, 0);
    @(negedge clk);
    #1;
    chk("resume data2", data_b, 8'hC2);
    chk("resume last2", last_b, 0);
    chk("resume frames", fd_b, 67);

    en_a = 1;
    rdy_a = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_a(8'(8'h10 + i));
    repeat (2) @(negedge clk);
    #1;
    chk("full busy", busy_a, 1);
    chk("full valid", valid_a, 1);
    chk("full rd_en", rd_a, 0);
    chk("full data", data_a, 8'h10);
    @(negedge clk);
    reset = 1;
    #1;
    chk("in-reset rd_en", rd_a, 0);
    @(negedge clk);
    #1;
    chk("post-reset valid", valid_a, 0);
    chk("post-reset busy", busy_a, 0);
    chk("post-reset frames", fd_a, 0);
    chk("post-reset rd_en", rd_a, 0);
    reset = 0;
    rdy_a = 1;
    push_a(8'h14);
    push_a(8'h15);
    e6[0] = 8'h12;
    e6[1] = 8'h13;
    e6[2] = 8'h14;
    e6[3] = 8'h15;
    k = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      #1;
      if (valid_a && rdy_a) begin
        if (k < 4) begin
          chk($sformatf("rst data%0d", k), data_a, e6[k]);
          chk($sformatf("rst last%0d", k), last_a, int'(k == 3));
        end
        k++;
      end
    end
    chk("rst count", k, 4);
    chk("rst frames", fd_a, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
